// File: rtl/row_result_writeback.sv
// Row result writeback stage: accumulates per-row group sums from the adder
// tree, queues finished rows in a small FIFO and streams them to the result
// SRAM over a valid/ready write port, flagging completion after NUM_ROWS rows.
module row_result_writeback #(
  parameter int DATA_W     = 24,
  parameter int ADDR_W     = 11,
  parameter int FIFO_DEPTH = 4,     // power of 2, at least 2
  parameter int NUM_ROWS   = 512,
  parameter int BASE_ADDR  = 0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [DATA_W-1:0] sum_in,
  input  logic              sum_valid,
  input  logic              row_end,
  input  logic              wr_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic [ADDR_W:0]   row_count,
  output logic              sat_flag,
  output logic              ovf_flag,
  output logic              done
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic {ST_RUN, ST_DONE} state_t;

  state_t              state_q, state_d;
  logic [DATA_W-1:0]   acc_q, acc_d;
  logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic [ADDR_W-1:0]   next_addr_q, next_addr_d;
  logic [ADDR_W:0]     row_count_q, row_count_d;
  logic                sat_q, sat_d;
  logic                ovf_q, ovf_d;

  // Each FIFO entry carries its row result and the SRAM address it belongs to.
  logic [DATA_W-1:0]   fifo_data_q [FIFO_DEPTH];
  logic [ADDR_W-1:0]   fifo_addr_q [FIFO_DEPTH];

  logic [DATA_W:0]     sum_ext;
  logic                clamp_hi;
  logic                clamp_lo;
  logic [DATA_W-1:0]   total;
  logic                fifo_empty;
  logic                fifo_full;
  logic                pop;
  logic                push_req;
  logic                push_ok;

  // Sign-extended add with one guard bit; guard/MSB disagreement means overflow.
  always_comb begin
    sum_ext  = {acc_q[DATA_W-1], acc_q} + {sum_in[DATA_W-1], sum_in};
    clamp_hi = ~sum_ext[DATA_W] &  sum_ext[DATA_W-1];
    clamp_lo =  sum_ext[DATA_W] & ~sum_ext[DATA_W-1];
    if (clamp_hi) begin
      total = {1'b0, {(DATA_W-1){1'b1}}};
    end else if (clamp_lo) begin
      total = {1'b1, {(DATA_W-1){1'b0}}};
    end else begin
      total = sum_ext[DATA_W-1:0];
    end
  end

  // Handshake decode: pops only while running, a push into a full FIFO is
  // still accepted when the head leaves on the same edge.
  always_comb begin
    fifo_empty = (count_q == '0);
    fifo_full  = (count_q == CNT_W'(FIFO_DEPTH));
    pop        = (state_q == ST_RUN) && !fifo_empty && wr_ready;
    push_req   = (state_q == ST_RUN) && sum_valid && row_end;
    push_ok    = push_req && (!fifo_full || pop);
  end

  // Next-state logic for the run/done FSM, accumulator, pointers and flags.
  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    rd_ptr_d    = rd_ptr_q;
    wr_ptr_d    = wr_ptr_q;
    count_d     = count_q;
    next_addr_d = next_addr_q;
    row_count_d = row_count_q;
    sat_d       = sat_q;
    ovf_d       = ovf_q;

    if ((state_q == ST_RUN) && sum_valid) begin
      if (clamp_hi || clamp_lo) begin
        sat_d = 1'b1;
      end
      // A finished row always clears the accumulator, even if it is dropped.
      acc_d = row_end ? '0 : total;
    end

    if (push_req && !push_ok) begin
      ovf_d = 1'b1;
    end

    if (push_ok) begin
      wr_ptr_d    = wr_ptr_q + 1'b1;
      next_addr_d = next_addr_q + 1'b1;
    end

    if (pop) begin
      rd_ptr_d    = rd_ptr_q + 1'b1;
      row_count_d = row_count_q + 1'b1;
      if (row_count_q == (ADDR_W+1)'(NUM_ROWS - 1)) begin
        state_d = ST_DONE;
      end
    end

    case ({push_ok, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // State register with synchronous reset; reset discards all queued rows.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= ST_RUN;
      acc_q       <= '0;
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      count_q     <= '0;
      next_addr_q <= ADDR_W'(BASE_ADDR);
      row_count_q <= '0;
      sat_q       <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      count_q     <= count_d;
      next_addr_q <= next_addr_d;
      row_count_q <= row_count_d;
      sat_q       <= sat_d;
      ovf_q       <= ovf_d;
    end
  end

  // FIFO storage; contents are only observed through count_q, so no reset.
  always_ff @(posedge clock) begin
    if (push_ok && !reset) begin
      fifo_data_q[wr_ptr_q] <= total;
      fifo_addr_q[wr_ptr_q] <= next_addr_q;
    end
  end

  // Outputs come only from registered state; an empty FIFO shows the next
  // row's address and zero data.
  always_comb begin
    wr_en     = (state_q == ST_RUN) && !fifo_empty;
    wr_addr   = fifo_empty ? next_addr_q : fifo_addr_q[rd_ptr_q];
    wr_data   = fifo_empty ? '0 : fifo_data_q[rd_ptr_q];
    row_count = row_count_q;
    sat_flag  = sat_q;
    ovf_flag  = ovf_q;
    done      = (state_q == ST_DONE);
  end

endmodule

// File: tb/tb_row_result_writeback.sv
// Testbench for row_result_writeback: directed scenarios plus randomized
// traffic, checked each cycle against a queue-based reference model.
module tb_row_result_writeback;

  logic        clock = 1'b0;
  logic        reset, reset2;
  logic [23:0] sum_in, s2_sum;
  logic        sum_valid, row_end, wr_ready;
  logic        s2_valid, s2_end, s2_ready;
  logic        wr_en, w2_en;
  logic [10:0] wr_addr, w2_addr;
  logic [23:0] wr_data, w2_data;
  logic [11:0] row_count, w2_count;
  logic        sat_flag, ovf_flag, done;
  logic        w2_sat, w2_ovf, w2_done;

  int checks = 0;
  int failures = 0;

  always #5 clock = ~clock;

  row_result_writeback dut (
    .clock(clock), .reset(reset), .sum_in(sum_in), .sum_valid(sum_valid),
    .row_end(row_end), .wr_ready(wr_ready), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .row_count(row_count), .sat_flag(sat_flag),
    .ovf_flag(ovf_flag), .done(done)
  );

  row_result_writeback #(.NUM_ROWS(4), .BASE_ADDR(2046)) dut2 (
    .clock(clock), .reset(reset2), .sum_in(s2_sum), .sum_valid(s2_valid),
    .row_end(s2_end), .wr_ready(s2_ready), .wr_en(w2_en), .wr_addr(w2_addr),
    .wr_data(w2_data), .row_count(w2_count), .sat_flag(w2_sat),
    .ovf_flag(w2_ovf), .done(w2_done)
  );

  // Reference model for dut: a queue of completed rows with plain integer math.
  typedef struct { int addr; int data; } ent_t;
  ent_t    mq[$];
  longint  m_acc;
  int      m_next_addr;
  int      m_count;
  bit      m_sat, m_ovf, m_done;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_update();
    bit     do_pop;
    int     sz;
    longint t;
    ent_t   e;
    if (reset) begin
      mq.delete();
      m_acc = 0; m_next_addr = 0; m_count = 0;
      m_sat = 0; m_ovf = 0; m_done = 0;
    end else begin
      sz = mq.size();
      do_pop = !m_done && (sz > 0) && wr_ready;
      if (sum_valid && !m_done) begin
        t = m_acc + longint'($signed(sum_in));
        if (t > 8388607)  begin t = 8388607;  m_sat = 1; end
        if (t < -8388608) begin t = -8388608; m_sat = 1; end
        if (row_end) begin
          if (sz < 4 || do_pop) begin
            e.addr = m_next_addr;
            e.data = int'(t) & 32'h00FF_FFFF;
            mq.push_back(e);
            m_next_addr = (m_next_addr + 1) % 2048;
          end else begin
            m_ovf = 1;
          end
          m_acc = 0;
        end else begin
          m_acc = t;
        end
      end
      if (do_pop) begin
        void'(mq.pop_front());
        m_count++;
        if (m_count == 512) m_done = 1;
      end
    end
  endtask

  task automatic compare_all();
    bit exp_en;
    exp_en = !m_done && (mq.size() > 0);
    check_val("wr_en", {31'b0, wr_en}, {31'b0, exp_en});
    if (exp_en) begin
      check_val("wr_addr", {21'b0, wr_addr}, mq[0].addr);
      check_val("wr_data", {8'b0, wr_data}, mq[0].data);
    end
    check_val("row_count", {20'b0, row_count}, m_count);
    check_val("sat_flag", {31'b0, sat_flag}, {31'b0, m_sat});
    check_val("ovf_flag", {31'b0, ovf_flag}, {31'b0, m_ovf});
    check_val("done", {31'b0, done}, {31'b0, m_done});
  endtask

  task automatic tick();
    @(posedge clock);
    model_update();
    #1;
    compare_all();
  endtask

  task automatic drv(input bit v, input bit e, input int val, input bit rdy);
    sum_valid = v; row_end = e; sum_in = 24'(val); wr_ready = rdy;
    tick();
  endtask

  task automatic do_reset();
    reset = 1; sum_valid = 0; row_end = 0;
    tick();
    reset = 0;
  endtask

  task automatic drv2(input bit v, input int val);
    s2_valid = v; s2_end = v; s2_sum = 24'(val); s2_ready = 1;
    tick();
  endtask

  task automatic chk_head(input string tag, input int a, input int d);
    check_val({tag, "_en"}, {31'b0, wr_en}, 1);
    check_val({tag, "_addr"}, {21'b0, wr_addr}, a);
    check_val({tag, "_data"}, {8'b0, wr_data}, d);
  endtask

  initial begin
    reset = 1; reset2 = 1;
    sum_in = 0; sum_valid = 0; row_end = 0; wr_ready = 0;
    s2_sum = 0; s2_valid = 0; s2_end = 0; s2_ready = 0;
    tick(); tick();
    check_val("rst_wr_en", {31'b0, wr_en}, 0);
    check_val("rst_wr_addr", {21'b0, wr_addr}, 0);
    check_val("rst_wr_data", {8'b0, wr_data}, 0);
    check_val("rst_row_count", {20'b0, row_count}, 0);
    check_val("rst_flags", {29'b0, sat_flag, ovf_flag, done}, 0);
    check_val("rst2_wr_addr", {21'b0, w2_addr}, 2046);
    reset = 0; reset2 = 0;

    // Done and address wrap on the second instance (NUM_ROWS=4, base 2046).
    for (int k = 0; k < 5; k++) begin
      drv2(1, 11 + k);
      if (k < 4) begin
        check_val("wrap_en", {31'b0, w2_en}, 1);
        check_val("wrap_addr", {21'b0, w2_addr}, (2046 + k) % 2048);
        check_val("wrap_data", {8'b0, w2_data}, 11 + k);
        check_val("wrap_count", {20'b0, w2_count}, k);
        check_val("wrap_done_early", {31'b0, w2_done}, 0);
      end
    end
    check_val("wrap_done", {31'b0, w2_done}, 1);
    check_val("wrap_count4", {20'b0, w2_count}, 4);
    check_val("wrap_en_off", {31'b0, w2_en}, 0);
    drv2(1, 77);
    drv2(0, 0);
    check_val("done_ignore_en", {31'b0, w2_en}, 0);
    check_val("done_ignore_count", {20'b0, w2_count}, 4);
    check_val("done_sticky", {31'b0, w2_done}, 1);

    // Single-group rows.
    do_reset();
    drv(1, 1, 5, 1);  chk_head("sg0", 0, 5);
    drv(1, 1, 7, 1);  chk_head("sg1", 1, 7);
    drv(1, 1, -3, 1); chk_head("sg2", 2, 24'hFFFFFD);
    drv(0, 0, 0, 1);
    check_val("sg_idle_en", {31'b0, wr_en}, 0);
    check_val("sg_count", {20'b0, row_count}, 3);

    // Multi-group row.
    do_reset();
    drv(1, 0, 100, 1); check_val("mg_en0", {31'b0, wr_en}, 0);
    drv(1, 0, 200, 1); check_val("mg_en1", {31'b0, wr_en}, 0);
    drv(1, 1, 300, 1); chk_head("mg", 0, 600);
    drv(0, 0, 0, 1);
    check_val("mg_idle_en", {31'b0, wr_en}, 0);
    check_val("mg_count", {20'b0, row_count}, 1);

    // Saturation.
    do_reset();
    drv(1, 0, 24'h7FFFF0, 1);
    check_val("sat_pre", {31'b0, sat_flag}, 0);
    drv(1, 1, 24'h000100, 1); chk_head("sat", 0, 24'h7FFFFF);
    check_val("sat_set", {31'b0, sat_flag}, 1);
    drv(1, 1, 1, 1); chk_head("sat_next", 1, 1);
    check_val("sat_sticky", {31'b0, sat_flag}, 1);

    // Backpressure and overflow.
    do_reset();
    for (int k = 1; k <= 5; k++) drv(1, 1, k, 0);
    check_val("ovf_set", {31'b0, ovf_flag}, 1);
    chk_head("bp0", 0, 1);
    for (int j = 1; j <= 3; j++) begin
      drv(0, 0, 0, 1); chk_head("bp", j, j + 1);
    end
    drv(0, 0, 0, 1);
    check_val("bp_idle_en", {31'b0, wr_en}, 0);
    check_val("bp_count", {20'b0, row_count}, 4);

    // Full FIFO with a same-edge pop and push: nothing dropped.
    do_reset();
    for (int k = 0; k < 4; k++) drv(1, 1, 21 + k, 0);
    drv(1, 1, 25, 1);
    check_val("full_no_ovf", {31'b0, ovf_flag}, 0);
    chk_head("full", 1, 22);
    for (int j = 2; j <= 4; j++) begin
      drv(0, 0, 0, 1); chk_head("full_drain", j, 21 + j);
    end
    drv(0, 0, 0, 1);
    check_val("full_count", {20'b0, row_count}, 5);

    // Reset in the middle of queued rows and a partial accumulation.
    do_reset();
    drv(1, 1, 31, 0);
    drv(1, 1, 32, 0);
    drv(1, 0, 50, 0);
    do_reset();
    check_val("mid_rst_en", {31'b0, wr_en}, 0);
    check_val("mid_rst_count", {20'b0, row_count}, 0);
    check_val("mid_rst_flags", {29'b0, sat_flag, ovf_flag, done}, 0);
    drv(1, 1, 9, 1); chk_head("mid_rst_row", 0, 9);

    // Randomized traffic against the model.
    do_reset();
    for (int c = 0; c < 4000; c++) begin
      int val;
      if ($urandom_range(0, 999) == 0) begin
        do_reset();
      end else begin
        case ($urandom_range(0, 3))
          0:       val = int'($urandom());
          1:       val = $urandom_range(0, 1) ? 32'h7FF000 + $urandom_range(0, 4095)
                                                 : -32'sh7FF000 - $urandom_range(0, 4095);
          default: val = $urandom_range(0, 2000) - 1000;
        endcase
        drv($urandom_range(0, 9) < 7, $urandom_range(0, 9) < 4, val,
            $urandom_range(0, 9) < 6);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
